// File: rtl/prog_lut_if.sv
// Lookup/write port bundle for prog_lut.
// The master side drives requests and writes; the slave side returns registered lookup results.
interface prog_lut_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned KW = 5
) ();
  logic          rd_req;
  logic [KW-1:0] rd_key;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_miss;
  logic          wr_en;
  logic [KW-1:0] wr_key;
  logic [DW-1:0] wr_data;

  modport master (
    output rd_req, rd_key, wr_en, wr_key, wr_data,
    input  rd_ready, rd_valid, rd_data, rd_miss
  );

  modport slave (
    input  rd_req, rd_key, wr_en, wr_key, wr_data,
    output rd_ready, rd_valid, rd_data, rd_miss
  );
endinterface

// File: rtl/prog_lut.sv
// Programmable lookup table: after reset an init sweep loads entry[i] = i, then lookups are
// served with one-cycle latency. Define PROG_LUT_WR_EN to enable the runtime write port.
module prog_lut #(
  parameter int unsigned DW    = 8,
  parameter int unsigned KW    = 5,
  parameter int unsigned DEPTH = 31
) (
  input  logic        i_clk,
  input  logic        i_reset,
  prog_lut_if.slave   bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [KW-1:0] r_idx;
  logic [KW-1:0] w_idx_nxt;

  logic [DW-1:0] r_mem [DEPTH];

  logic          r_rd_ready;
  logic          r_rd_valid;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_miss;

  logic          w_rd_acc;
  logic          w_rd_hit;
  logic [DW-1:0] w_rd_word;

`ifdef PROG_LUT_WR_EN
  logic          w_wr_acc;
  logic          w_wr_bypass;
`else
  logic          w_unused_wr;
  assign w_unused_wr = ^{bus.wr_en, bus.wr_key, bus.wr_data};
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: sweep one entry per cycle, then stay in RUN until reset
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_INIT: begin
        w_idx_nxt = r_idx + KW'(1);
        if (r_idx == KW'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Request qualification and read word selection (write-first on a same-key collision)
  always_comb begin
    w_rd_acc  = (r_state == ST_RUN) && bus.rd_req;
    w_rd_hit  = (32'(bus.rd_key) < DEPTH);
    w_rd_word = r_mem[AW'(bus.rd_key)];
`ifdef PROG_LUT_WR_EN
    w_wr_acc    = (r_state == ST_RUN) && bus.wr_en && (32'(bus.wr_key) < DEPTH);
    w_wr_bypass = w_wr_acc && (bus.wr_key == bus.rd_key);
    if (w_wr_bypass) begin
      w_rd_word = bus.wr_data;
    end
`endif
  end

  // Table storage; contents need no reset because INIT rewrites every entry
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (r_state == ST_INIT) begin
        r_mem[AW'(r_idx)] <= DW'(r_idx);
      end
`ifdef PROG_LUT_WR_EN
      else if (w_wr_acc) begin
        r_mem[AW'(bus.wr_key)] <= bus.wr_data;
      end
`endif
    end
  end

  // Registered lookup results; data/miss hold when no lookup returns
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_ready <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_miss  <= 1'b0;
    end else begin
      r_rd_ready <= (w_state_nxt == ST_RUN);
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        if (w_rd_hit) begin
          r_rd_data <= w_rd_word;
          r_rd_miss <= 1'b0;
        end else begin
          r_rd_data <= '0;
          r_rd_miss <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_ready = r_rd_ready;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_miss  = r_rd_miss;

endmodule
